// File: rtl/vga_cap_pkg.sv
// Shared constants and FSM state type for the VGA grid capture block.
// Defaults match the 640x480 game display with a 20x15 cell grid.
package vga_cap_pkg;

   localparam int WIDTH_DEF  = 640;
   localparam int HEIGHT_DEF = 480;
   localparam int ROWS_DEF   = 15;
   localparam int COLS_DEF   = 20;

   typedef enum logic [1:0] {
      IDLE,
      WAIT_ACTIVE,
      CAPTURE,
      PUBLISH
   } cap_state_e;

   // Counter width able to hold 0..n inclusive (counters saturate at n).
   function automatic int cnt_w(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/vga_pos_tracker.sv
// Sync/blank edge detection and saturating x/y position counters.
// Run-length checks exist only with VGA_CAP_TIMING_CHECK_EN defined.
module vga_pos_tracker
   import vga_cap_pkg::*;
#(
   parameter int WIDTH  = WIDTH_DEF,
   parameter int HEIGHT = HEIGHT_DEF,
   parameter int XW     = cnt_w(WIDTH_DEF),
   parameter int YW     = cnt_w(HEIGHT_DEF)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          vga_vs,
   input  logic          vga_blank_n,
   output logic          vs_fall_o,
   output logic [XW-1:0] x_o,
   output logic [YW-1:0] y_o,
   output logic          line_bad_o,
   output logic          frame_bad_o
);

   localparam logic [XW-1:0] XMAX = XW'(WIDTH);
   localparam logic [YW-1:0] YMAX = YW'(HEIGHT);

   logic          vs_q;
   logic          blank_q;
   logic [XW-1:0] x_q, x_d;
   logic [YW-1:0] y_q, y_d;
   logic          blank_rise;
   logic          blank_fall;

   assign vs_fall_o  = vs_q & ~vga_vs;
   assign blank_rise = vga_blank_n & ~blank_q;
   assign blank_fall = blank_q & ~vga_blank_n;

   // x_o is the index of the pixel on the bus this cycle.
   assign x_o = blank_rise ? '0 : x_q;
   assign y_o = y_q;

   always_comb begin
      x_d = x_q;
      if (vga_blank_n) begin
         x_d = (x_o == XMAX) ? x_o : x_o + 1'b1;
      end
      y_d = y_q;
      if (vs_fall_o) begin
         y_d = '0;
      end else if (blank_fall && (y_q != YMAX)) begin
         y_d = y_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vs_q    <= 1'b1;
         blank_q <= 1'b0;
         x_q     <= '0;
         y_q     <= '0;
      end else begin
         vs_q    <= vga_vs;
         blank_q <= vga_blank_n;
         x_q     <= x_d;
         y_q     <= y_d;
      end
   end

`ifdef VGA_CAP_TIMING_CHECK_EN
   assign line_bad_o  = blank_fall & (x_q != XMAX);
   assign frame_bad_o = vs_fall_o & (y_q != YMAX);
`else
   assign line_bad_o  = 1'b0;
   assign frame_bad_o = 1'b0;
`endif

endmodule

// File: rtl/vga_grid_capture.sv
// Samples cell-centre pixels of each VGA frame into a ROWS x COLS bit map.
// Define VGA_CAP_TIMING_CHECK_EN to enable line_err/frame_err checking.
module vga_grid_capture
   import vga_cap_pkg::*;
#(
   parameter int WIDTH  = WIDTH_DEF,
   parameter int HEIGHT = HEIGHT_DEF,
   parameter int ROWS   = ROWS_DEF,
   parameter int COLS   = COLS_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 vga_hs,
   input  logic                 vga_vs,
   input  logic                 vga_blank_n,
   input  logic [7:0]           vga_r,
   input  logic [7:0]           vga_g,
   input  logic [7:0]           vga_b,
   input  logic                 frame_ack,
   output logic [ROWS*COLS-1:0] grid,
   output logic                 frame_valid,
   output logic                 overrun,
   output logic                 line_err,
   output logic                 frame_err
);

   localparam int CELL_W = WIDTH / COLS;
   localparam int CELL_H = HEIGHT / ROWS;
   localparam int XW     = cnt_w(WIDTH);
   localparam int YW     = cnt_w(HEIGHT);
   localparam int NCELL  = ROWS * COLS;

   cap_state_e       state_q, state_d;
   logic [NCELL-1:0] shadow_q, shadow_d;
   logic [NCELL-1:0] grid_q, grid_d;
   logic             fv_q, fv_d;
   logic             ovr_q, ovr_d;

   logic             vs_fall;
   logic [XW-1:0]    x;
   logic [YW-1:0]    y;
   logic             line_bad;
   logic             frame_bad;
   logic [ROWS-1:0]  row_hit;
   logic [COLS-1:0]  col_hit;
   logic [NCELL-1:0] hit;
   logic             pix_on;
   logic             sample_en;
   logic             unused_hs;

   assign unused_hs = vga_hs;

   vga_pos_tracker #(
      .WIDTH  (WIDTH),
      .HEIGHT (HEIGHT),
      .XW     (XW),
      .YW     (YW)
   ) u_pos (
      .clk         (clk),
      .rst         (rst),
      .vga_vs      (vga_vs),
      .vga_blank_n (vga_blank_n),
      .vs_fall_o   (vs_fall),
      .x_o         (x),
      .y_o         (y),
      .line_bad_o  (line_bad),
      .frame_bad_o (frame_bad)
   );

   for (genvar r = 0; r < ROWS; r++) begin : g_row
      assign row_hit[r] = (y == YW'(r * CELL_H + CELL_H / 2));
   end

   for (genvar c = 0; c < COLS; c++) begin : g_col
      assign col_hit[c] = (x == XW'(c * CELL_W + CELL_W / 2));
   end

   for (genvar r = 0; r < ROWS; r++) begin : g_hr
      for (genvar c = 0; c < COLS; c++) begin : g_hc
         assign hit[r*COLS+c] = row_hit[r] & col_hit[c];
      end
   end

   assign pix_on = |{vga_r, vga_g, vga_b};

   // First active pixel arrives in WAIT_ACTIVE and must not be lost.
   assign sample_en = vga_blank_n &
                      ((state_q == CAPTURE) || (state_q == WAIT_ACTIVE));

   always_comb begin
      state_d  = state_q;
      shadow_d = shadow_q;
      grid_d   = grid_q;
      fv_d     = fv_q;
      ovr_d    = ovr_q;
      if (frame_ack && fv_q) begin
         fv_d = 1'b0;
      end
      unique case (state_q)
         IDLE: begin
            if (vs_fall) state_d = WAIT_ACTIVE;
         end
         WAIT_ACTIVE: begin
            if (vga_blank_n) begin
               state_d  = CAPTURE;
               shadow_d = '0;
            end
         end
         CAPTURE: begin
            if (vs_fall) state_d = PUBLISH;
         end
         PUBLISH: begin
            state_d = WAIT_ACTIVE;
            if (!fv_q || frame_ack) begin
               grid_d = shadow_q;
               fv_d   = 1'b1;
            end else begin
               ovr_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      if (sample_en) begin
         shadow_d = (shadow_d & ~hit) | (hit & {NCELL{pix_on}});
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         shadow_q <= '0;
         grid_q   <= '0;
         fv_q     <= 1'b0;
         ovr_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         shadow_q <= shadow_d;
         grid_q   <= grid_d;
         fv_q     <= fv_d;
         ovr_q    <= ovr_d;
      end
   end

   assign grid        = grid_q;
   assign frame_valid = fv_q;
   assign overrun     = ovr_q;

`ifdef VGA_CAP_TIMING_CHECK_EN
   logic line_err_q;
   logic frame_err_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         line_err_q  <= 1'b0;
         frame_err_q <= 1'b0;
      end else if (state_q == CAPTURE) begin
         if (line_bad)  line_err_q  <= 1'b1;
         if (frame_bad) frame_err_q <= 1'b1;
      end
   end

   assign line_err  = line_err_q;
   assign frame_err = frame_err_q;
`else
   logic unused_err;

   assign unused_err = line_bad | frame_bad;
   assign line_err   = 1'b0;
   assign frame_err  = 1'b0;
`endif

endmodule

// File: tb/tb_vga_grid_capture.sv
// Directed bench for vga_grid_capture on a reduced 16x12 raster, 3x4 grid.
module tb_vga_grid_capture;

   localparam int W = 16;
   localparam int H = 12;

`ifdef VGA_CAP_TIMING_CHECK_EN
   localparam logic TC = 1'b1;
`else
   localparam logic TC = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        vga_hs = 1'b1;
   logic        vga_vs = 1'b1;
   logic        vga_blank_n = 1'b0;
   logic [7:0]  vga_r = '0;
   logic [7:0]  vga_g = '0;
   logic [7:0]  vga_b = '0;
   logic        frame_ack = 1'b0;
   logic [11:0] grid;
   logic        frame_valid;
   logic        overrun;
   logic        line_err;
   logic        frame_err;

   int checks = 0;
   int errors = 0;

   vga_grid_capture #(
      .WIDTH  (W),
      .HEIGHT (H),
      .ROWS   (3),
      .COLS   (4)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .vga_hs      (vga_hs),
      .vga_vs      (vga_vs),
      .vga_blank_n (vga_blank_n),
      .vga_r       (vga_r),
      .vga_g       (vga_g),
      .vga_b       (vga_b),
      .frame_ack   (frame_ack),
      .grid        (grid),
      .frame_valid (frame_valid),
      .overrun     (overrun),
      .line_err    (line_err),
      .frame_err   (frame_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input logic bn, input logic [23:0] rgb);
      vga_blank_n = bn;
      {vga_r, vga_g, vga_b} = rgb;
      @(negedge clk);
   endtask

   function automatic logic [23:0] pix(input logic [11:0] pat, input int x,
                                       input int y, input bit noise);
      bit lit;
      if ((x % 4 == 2) && (y % 4 == 2))
         lit = ((pat >> ((y / 4) * 4 + x / 4)) & 12'd1) != 12'd0;
      else
         lit = noise;
      if (!lit) return 24'h0;
      case ((x + y) % 3)
         0:       return 24'h800000;
         1:       return 24'h000100;
         default: return 24'h0000FF;
      endcase
   endfunction

   task automatic body(input logic [11:0] pat, input int nlines,
                       input int short_ln, input bit noise);
      logic [23:0] hb;
      hb = noise ? 24'hFFFFFF : 24'h0;
      repeat (2) tick(1'b0, hb);
      for (int y = 0; y < nlines; y++) begin
         int npx;
         npx = (y == short_ln) ? W - 1 : W;
         for (int x = 0; x < npx; x++) tick(1'b1, pix(pat, x, y, noise));
         tick(1'b0, hb);
         vga_hs = 1'b0;
         tick(1'b0, hb);
         tick(1'b0, hb);
         vga_hs = 1'b1;
         tick(1'b0, hb);
      end
      repeat (3) tick(1'b0, 24'h0);
   endtask

   task automatic vsync(input bit ack2);
      vga_vs = 1'b0;
      tick(1'b0, 24'h0);
      frame_ack = ack2;
      tick(1'b0, 24'h0);
      frame_ack = 1'b0;
      vga_vs = 1'b1;
      tick(1'b0, 24'h0);
      tick(1'b0, 24'h0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick(1'b0, 24'h0);
      tick(1'b0, 24'h0);
      rst = 1'b0;
      tick(1'b0, 24'h0);
   endtask

   task automatic chk_all(input string tag, input logic [11:0] g,
                          input logic fv, input logic ov,
                          input logic le, input logic fe);
      chk({tag, ".grid"}, 32'(grid), 32'(g));
      chk({tag, ".fv"}, 32'(frame_valid), 32'(fv));
      chk({tag, ".ovr"}, 32'(overrun), 32'(ov));
      chk({tag, ".lerr"}, 32'(line_err), 32'(le));
      chk({tag, ".ferr"}, 32'(frame_err), 32'(fe));
   endtask

   initial begin
      @(negedge clk);
      do_reset();
      chk_all("reset", 12'h000, 1'b0, 1'b0, 1'b0, 1'b0);

      // Single lit centre (x=6,y=10) in cell [2][1]; all other pixels noisy.
      vsync(1'b0);
      body(12'h200, H, -1, 1'b1);
      chk("pre_pub.fv", 32'(frame_valid), 32'd0);
      vsync(1'b0);
      chk_all("frameA", 12'h200, 1'b1, 1'b0, 1'b0, 1'b0);

      // Second frame with no ack is dropped.
      body(12'h861, H, -1, 1'b0);
      vsync(1'b0);
      chk_all("drop", 12'h200, 1'b1, 1'b1, 1'b0, 1'b0);

      // Ack in the PUBLISH cycle lets frame 2 through.
      do_reset();
      vsync(1'b0);
      body(12'h200, H, -1, 1'b0);
      vsync(1'b0);
      chk("ackA.grid", 32'(grid), 32'h200);
      body(12'h861, H, -1, 1'b1);
      vsync(1'b1);
      chk_all("ackpub", 12'h861, 1'b1, 1'b0, 1'b0, 1'b0);
      frame_ack = 1'b1;
      tick(1'b0, 24'h0);
      frame_ack = 1'b0;
      chk("ack.fv", 32'(frame_valid), 32'd0);
      chk("ack.grid", 32'(grid), 32'h861);
      frame_ack = 1'b1;
      tick(1'b0, 24'h0);
      frame_ack = 1'b0;
      tick(1'b0, 24'h0);
      chk("ack_idle.fv", 32'(frame_valid), 32'd0);
      chk("ack_idle.grid", 32'(grid), 32'h861);

      // One short line: error only with checking built in, frame still published.
      do_reset();
      vsync(1'b0);
      body(12'h0F0, H, 5, 1'b0);
      vsync(1'b0);
      chk_all("short_line", 12'h0F0, 1'b1, 1'b0, TC, 1'b0);

      // Reset mid-frame after line 7, then a clean frame.
      vsync(1'b0);
      body(12'hFFF, 7, -1, 1'b1);
      do_reset();
      chk_all("mid_rst", 12'h000, 1'b0, 1'b0, 1'b0, 1'b0);
      body(12'hFFF, 4, -1, 1'b1);
      vsync(1'b0);
      chk("mid_rst.idle_fv", 32'(frame_valid), 32'd0);
      body(12'h5A3, H, -1, 1'b1);
      vsync(1'b0);
      chk_all("after_rst", 12'h5A3, 1'b1, 1'b0, 1'b0, 1'b0);

      // Frame one line short.
      do_reset();
      vsync(1'b0);
      body(12'hC35, H - 1, -1, 1'b0);
      vsync(1'b0);
      chk_all("short_frame", 12'hC35, 1'b1, 1'b0, 1'b0, TC);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
